vcsr_reader: RTL and testbench

- Read-side counterpart of the VCSR write mapping.
- Accepts a read request for a virtual CSR index and looks up that VCSR's config entry (target addr, bit offset, width).
- Issues a handshaked read to the CSR file, then extracts the field, right-aligns it and returns it on a response handshake.
- Sits between the CSR-access stage and the CSR file, alongside the VCSR config CSRs.

---
 rtl/vcsr_reader_pkg.sv | 37 +++
 rtl/vcsr_field_extract.sv | 33 +++
 rtl/vcsr_reader.sv | 137 +++++++++++++
 tb/tb_vcsr_reader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vcsr_reader_pkg.sv
// vcsr_reader_pkg: shared types for the VCSR read path.
//   CsrAddrT / word   : CSR address and data word types
//   vcsr_cfg_entry_t  : packed config entry {addr, offset, width}, also used by the write path
//   vcsr_rd_state_t   : read-path FSM states
//   vcsr_idx_t        : request index for the default 16-entry configuration
//   field_mask()      : ones in bits [top_bit:0], also used by the write path
package vcsr_reader_pkg;

  localparam int unsigned CsrAddrW = 12;
  typedef logic [CsrAddrW-1:0] CsrAddrT;
  typedef logic [31:0]         word;

  // Config CSR k lives at VcsrBase + k.
  localparam CsrAddrT VcsrBase = 12'h100;
  localparam int unsigned VcsrAmountDefault = 16;

  typedef logic [$clog2(VcsrAmountDefault):0] vcsr_idx_t;

  typedef struct packed {
    CsrAddrT    addr;
    logic [4:0] offset;
    logic [4:0] width;   // field is width+1 bits wide
  } vcsr_cfg_entry_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_LOOKUP,
    RD_CSR_RD,
    RD_RESP
  } vcsr_rd_state_t;

  // A shift by 32 yields zero, so top_bit=31 gives an all-ones mask.
  function automatic word field_mask(input logic [4:0] top_bit);
    return ~(32'hFFFF_FFFF << ({1'b0, top_bit} + 6'd1));
  endfunction

endpackage

// File: rtl/vcsr_field_extract.sv
// vcsr_field_extract: combinational field extraction.
//   data_i   : raw CSR word
//   offset_i : LSB position of the field
//   width_i  : field width minus one
//   field_o  : field right-aligned, masked and extended
// Build option VCSR_READ_SIGN_EXT_EN: sign-extend instead of zero-extend.
module vcsr_field_extract
  import vcsr_reader_pkg::*;
(
  input  word        data_i,
  input  logic [4:0] offset_i,
  input  logic [4:0] width_i,
  output word        field_o
);

  word        shifted;
  word        mask;
  logic [5:0] span;
  logic [4:0] top_bit;

  always_comb begin
    shifted = data_i >> offset_i;
    span    = {1'b0, offset_i} + {1'b0, width_i};
    // A field running past bit 31 is truncated; its top is then bit 31-offset.
    top_bit = span[5] ? (5'd31 - offset_i) : width_i;
    mask    = field_mask(top_bit);
    field_o = shifted & mask;
`ifdef VCSR_READ_SIGN_EXT_EN
    if (shifted[top_bit]) field_o = field_o | ~mask;
`endif
  end

endmodule

// File: rtl/vcsr_reader.sv
// vcsr_reader: read side of the VCSR mapping. A request for virtual CSR idx
// looks up config entry cfg_i[idx], reads the target CSR and returns the
// right-aligned field. One request in flight at a time.
//   clk_i, rst_ni            : clock, async active-low reset
//   cfg_i[VcsrAmount]        : config CSR contents, {addr, offset, width} in bits [21:0]
//   req_valid_i/req_ready_o  : request handshake, req_idx_i selects the VCSR
//   csr_rd_valid_o/ready_i   : CSR file read, csr_rd_data_i valid with ready
//   resp_valid_o/resp_ready_i: response handshake with resp_data_o, resp_err_o
// Build option VCSR_READ_SIGN_EXT_EN: sign-extend returned fields.
//
// state     | meaning
// RD_IDLE   | waiting for a request, req_ready_o high
// RD_LOOKUP | index range check and config entry capture
// RD_CSR_RD | CSR read outstanding, address held
// RD_RESP   | response held until resp_ready_i
module vcsr_reader
  import vcsr_reader_pkg::*;
#(
  parameter  int unsigned VcsrAmount = VcsrAmountDefault,
  localparam int unsigned IdxW       = $clog2(VcsrAmount) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [31:0]     cfg_i [VcsrAmount],
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [IdxW-1:0] req_idx_i,
  output logic            csr_rd_valid_o,
  input  logic            csr_rd_ready_i,
  output CsrAddrT         csr_rd_addr_o,
  input  word             csr_rd_data_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output word             resp_data_o,
  output logic            resp_err_o
);

  vcsr_rd_state_t  state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  CsrAddrT         addr_q, addr_d;
  logic [4:0]      offset_q, offset_d;
  logic [4:0]      width_q, width_d;
  word             resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;

  logic            idx_in_range;
  vcsr_cfg_entry_t cfg_sel;
  word             field;
  logic            unused_cfg_hi;

  assign idx_in_range = (32'(idx_q) < VcsrAmount);
  // Out-of-range indices alias into the table but are rejected before use.
  assign cfg_sel = vcsr_cfg_entry_t'(cfg_i[idx_q[IdxW-2:0]][21:0]);

  always_comb begin
    unused_cfg_hi = 1'b0;
    for (int k = 0; k < VcsrAmount; k++) unused_cfg_hi = unused_cfg_hi ^ (^cfg_i[k][31:22]);
  end

  vcsr_field_extract u_extract (
    .data_i   (csr_rd_data_i),
    .offset_i (offset_q),
    .width_i  (width_q),
    .field_o  (field)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    offset_d    = offset_q;
    width_d     = width_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    unique case (state_q)
      RD_IDLE: begin
        if (req_valid_i) begin
          idx_d   = req_idx_i;
          state_d = RD_LOOKUP;
        end
      end
      RD_LOOKUP: begin
        if (idx_in_range) begin
          addr_d   = cfg_sel.addr;
          offset_d = cfg_sel.offset;
          width_d  = cfg_sel.width;
          state_d  = RD_CSR_RD;
        end else begin
          resp_err_d  = 1'b1;
          resp_data_d = '0;
          state_d     = RD_RESP;
        end
      end
      RD_CSR_RD: begin
        if (csr_rd_ready_i) begin
          resp_data_d = field;
          state_d     = RD_RESP;
        end
      end
      RD_RESP: begin
        if (resp_ready_i) begin
          resp_err_d = 1'b0;
          state_d    = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RD_IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      offset_q    <= '0;
      width_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      offset_q    <= offset_d;
      width_q     <= width_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign req_ready_o    = (state_q == RD_IDLE);
  assign csr_rd_valid_o = (state_q == RD_CSR_RD);
  assign resp_valid_o   = (state_q == RD_RESP);
  assign csr_rd_addr_o  = addr_q;
  assign resp_data_o    = resp_data_q;
  assign resp_err_o     = resp_err_q;

endmodule

// File: tb/tb_vcsr_reader.sv
// tb_vcsr_reader: randomized and directed bench for vcsr_reader with a
// bit-level reference model of field extraction.
module tb_vcsr_reader;

`ifdef VCSR_READ_SIGN_EXT_EN
  localparam bit SignExt = 1'b1;
`else
  localparam bit SignExt = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] cfg [16];
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_idx;
  logic        csr_rd_valid;
  logic        csr_rd_ready;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  vcsr_reader #(.VcsrAmount(16)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cfg_i          (cfg),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_idx_i      (req_idx),
    .csr_rd_valid_o (csr_rd_valid),
    .csr_rd_ready_i (csr_rd_ready),
    .csr_rd_addr_o  (csr_rd_addr),
    .csr_rd_data_i  (csr_rd_data),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_data_o    (resp_data),
    .resp_err_o     (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: copy field bits one at a time, stopping at bit 31 of the word.
  function automatic logic [31:0] model(input logic [31:0] entry, input logic [31:0] data);
    int off, w, top;
    logic [31:0] r;
    off = int'(entry[9:5]);
    w   = int'(entry[4:0]);
    top = (off + w > 31) ? 31 - off : w;
    r   = '0;
    for (int b = 0; b <= top; b++) r[b] = data[off + b];
    if (SignExt && r[top]) for (int b = top + 1; b < 32; b++) r[b] = 1'b1;
    return r;
  endfunction

  // Results of the last run_req call.
  logic [31:0] r_data;
  logic        r_err;
  logic [11:0] r_addr;
  bit          r_rd_seen, r_ok, r_addr_bad, r_hold_bad, r_rdy_bad;
  int          r_rd_first, r_lat;

  task automatic run_req(input logic [4:0] idx, input logic [31:0] rdata, input int rd_wait,
                         input int rsp_wait, input bit queue_next, input logic [4:0] next_idx);
    int cyc, rd_cnt, rsp_cnt, rd_hs, rsp_first, w;
    bit done;
    r_rd_seen = 0; r_ok = 0; r_addr_bad = 0; r_hold_bad = 0; r_rdy_bad = 0;
    r_rd_first = -1; r_lat = -1; r_data = '0; r_err = 1'b0; r_addr = '0;
    cyc = 0; rd_cnt = 0; rsp_cnt = 0; rd_hs = -1; rsp_first = -1; done = 0; w = 0;
    req_valid = 1'b1;
    req_idx   = idx;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!done && cyc < 100) begin
      if (req_ready) r_rdy_bad = 1;
      if (csr_rd_valid) begin
        if (!r_rd_seen) begin
          r_rd_seen  = 1;
          r_rd_first = cyc;
          r_addr     = csr_rd_addr;
          // Config changes after lookup must not affect this request.
          cfg[idx[3:0]] = $urandom;
        end else if (csr_rd_addr !== r_addr) r_addr_bad = 1;
        if (rd_cnt == rd_wait) begin
          csr_rd_ready = 1'b1;
          csr_rd_data  = rdata;
          rd_hs        = cyc;
        end
        rd_cnt++;
      end
      if (resp_valid) begin
        if (queue_next) begin
          req_valid = 1'b1;
          req_idx   = next_idx;
        end
        if (rsp_cnt == 0) begin
          rsp_first = cyc;
          r_data    = resp_data;
          r_err     = resp_err;
          r_lat     = (rd_hs >= 0) ? rsp_first - rd_hs : 0;
        end else if (resp_data !== r_data || resp_err !== r_err) r_hold_bad = 1;
        if (rsp_cnt == rsp_wait) begin
          resp_ready = 1'b1;
          done       = 1;
        end
        rsp_cnt++;
      end
      @(posedge clk); #1;
      csr_rd_ready = 1'b0;
      csr_rd_data  = $urandom;
      resp_ready   = 1'b0;
      cyc++;
    end
    r_ok = done;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (csr_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_csr_rd_valid: got %b want 0", csr_rd_valid); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    checks++; if (csr_rd_addr !== 12'h0) begin errors++; $display("FAIL reset_csr_rd_addr: got %h want 0", csr_rd_addr); end
  endtask

  task automatic test_directed();
    cfg[2] = {10'h2A5, 12'h300, 5'd4, 5'd3};
    run_req(5'd2, 32'hABCD_1234, 0, 0, 0, 5'd0);
    checks++; if (!r_ok) begin errors++; $display("FAIL directed_timeout: got no response want response"); end
    checks++; if (r_addr !== 12'h300) begin errors++; $display("FAIL directed_addr: got %h want 300", r_addr); end
    checks++; if (r_data !== 32'h3) begin errors++; $display("FAIL directed_data: got %h want 3", r_data); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL directed_err: got %b want 0", r_err); end
    checks++; if (r_rd_first !== 1) begin errors++; $display("FAIL directed_rd_latency: got %0d want 1", r_rd_first); end
    checks++; if (r_lat !== 1) begin errors++; $display("FAIL directed_resp_latency: got %0d want 1", r_lat); end
    checks++; if (r_rdy_bad) begin errors++; $display("FAIL directed_req_ready: got 1 want 0 while busy"); end
  endtask

  task automatic test_invalid_idx();
    logic [4:0] bad [2];
    bad[0] = 5'd16;
    bad[1] = 5'd31;
    for (int i = 0; i < 2; i++) begin
      run_req(bad[i], $urandom, 0, 1, 0, 5'd0);
      checks++; if (!r_ok) begin errors++; $display("FAIL invalid_timeout: idx %0d got no response", bad[i]); end
      checks++; if (r_rd_seen) begin errors++; $display("FAIL invalid_csr_rd: idx %0d got csr_rd_valid want none", bad[i]); end
      checks++; if (r_err !== 1'b1 || r_data !== 32'h0) begin
        errors++; $display("FAIL invalid_resp: idx %0d got err=%b data=%h want err=1 data=0", bad[i], r_err, r_data);
      end
    end
  endtask

  task automatic test_rd_stall();
    logic [31:0] d, e;
    cfg[7] = {10'h0, 12'h123, 5'd8, 5'd11};
    e = cfg[7];
    d = $urandom;
    run_req(5'd7, d, 5, 0, 0, 5'd0);
    checks++; if (r_addr_bad || r_addr !== 12'h123) begin
      errors++; $display("FAIL stall_addr: got %h unstable=%b want 123 stable", r_addr, r_addr_bad);
    end
    checks++; if (r_lat !== 1) begin errors++; $display("FAIL stall_resp_latency: got %0d want 1", r_lat); end
    checks++; if (r_data !== model(e, d)) begin errors++; $display("FAIL stall_data: got %h want %h", r_data, model(e, d)); end
  endtask

  task automatic test_overflow();
    logic [31:0] want;
    want = SignExt ? 32'hFFFF_FFFF : 32'h0000_000F;
    cfg[9] = {10'h0, 12'h104, 5'd28, 5'd7};
    run_req(5'd9, 32'hF000_0000, 1, 0, 0, 5'd0);
    checks++; if (r_data !== want || r_err !== 1'b0) begin
      errors++; $display("FAIL overflow: got data=%h err=%b want data=%h err=0", r_data, r_err, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2, d1, d2;
    cfg[3] = {10'h1, 12'h10C, 5'd0, 5'd15};
    cfg[4] = {10'h2, 12'h800, 5'd20, 5'd4};
    e1 = cfg[3]; e2 = cfg[4];
    d1 = $urandom; d2 = $urandom;
    run_req(5'd3, d1, 0, 3, 1, 5'd4);
    checks++; if (r_rdy_bad) begin errors++; $display("FAIL b2b_req_ready: got 1 want 0 until response done"); end
    checks++; if (r_hold_bad) begin errors++; $display("FAIL b2b_resp_hold: got changing response want stable"); end
    checks++; if (r_data !== model(e1, d1)) begin errors++; $display("FAIL b2b_first_data: got %h want %h", r_data, model(e1, d1)); end
    run_req(5'd4, d2, 0, 0, 0, 5'd0);
    checks++; if (r_addr !== e2[21:10] || r_data !== model(e2, d2) || r_err !== 1'b0) begin
      errors++; $display("FAIL b2b_second: got addr=%h data=%h err=%b want addr=%h data=%h err=0",
                         r_addr, r_data, r_err, e2[21:10], model(e2, d2));
    end
  endtask

  task automatic test_random();
    logic [4:0]  idx;
    logic [31:0] e, d;
    for (int n = 0; n < 40; n++) begin
      idx = 5'($urandom_range(0, 19));
      if (idx < 16) cfg[idx[3:0]] = $urandom;
      e = (idx < 16) ? cfg[idx[3:0]] : 32'h0;
      d = $urandom;
      run_req(idx, d, $urandom_range(0, 3), $urandom_range(0, 3), 0, 5'd0);
      checks++; if (!r_ok || r_rdy_bad || r_hold_bad || r_addr_bad) begin
        errors++; $display("FAIL random_handshake[%0d]: ok=%b rdy_bad=%b hold_bad=%b addr_bad=%b want 1000",
                           n, r_ok, r_rdy_bad, r_hold_bad, r_addr_bad);
      end
      if (idx >= 16) begin
        checks++; if (r_rd_seen || r_err !== 1'b1 || r_data !== 32'h0) begin
          errors++; $display("FAIL random_invalid[%0d]: idx %0d got rd=%b err=%b data=%h want rd=0 err=1 data=0",
                             n, idx, r_rd_seen, r_err, r_data);
        end
      end else begin
        checks++; if (r_addr !== e[21:10] || r_data !== model(e, d) || r_err !== 1'b0 || r_lat !== 1) begin
          errors++; $display("FAIL random_read[%0d]: idx %0d got addr=%h data=%h err=%b lat=%0d want addr=%h data=%h err=0 lat=1",
                             n, idx, r_addr, r_data, r_err, r_lat, e[21:10], model(e, d));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    logic [31:0] e, d;
    cfg[5] = {10'h0, 12'h2F0, 5'd2, 5'd9};
    req_valid = 1'b1;
    req_idx   = 5'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w = 0;
    while (!csr_rd_valid && w < 10) begin
      @(posedge clk); #1; w++;
    end
    checks++; if (!csr_rd_valid) begin errors++; $display("FAIL rstmid_reach_rd: got csr_rd_valid=0 want 1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || csr_rd_valid !== 1'b0 || resp_valid !== 1'b0 ||
                  resp_err !== 1'b0 || resp_data !== 32'h0 || csr_rd_addr !== 12'h0) begin
      errors++; $display("FAIL rstmid_outputs: got rdy=%b rdv=%b rsv=%b err=%b data=%h addr=%h want 1 0 0 0 0 0",
                         req_ready, csr_rd_valid, resp_valid, resp_err, resp_data, csr_rd_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    e = cfg[5];
    d = $urandom;
    run_req(5'd5, d, 0, 0, 0, 5'd0);
    checks++; if (!r_ok || r_addr !== 12'h2F0 || r_data !== model(e, d) || r_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_next: got ok=%b addr=%h data=%h err=%b want 1 2f0 %h 0",
                         r_ok, r_addr, r_data, r_err, model(e, d));
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) cfg[k] = $urandom;
    req_valid    = 1'b0;
    req_idx      = '0;
    csr_rd_ready = 1'b0;
    csr_rd_data  = '0;
    resp_ready   = 1'b0;
    rst_n        = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_invalid_idx();
    test_rd_stall();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
